// File: rtl/pipe_stage_latch.sv
// Elastic valid/ready pipeline latch with optional skid entry, flush and sticky halt.
// Define PIPE_STAGE_LATCH_STATS_EN to add stall_cnt/flush_cnt statistics outputs.
module pipe_stage_latch #(
  parameter int unsigned       DATA_W     = 128,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  input  logic              flush,
  output logic              halted
`ifdef PIPE_STAGE_LATCH_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              head_halt_q, head_halt_d;
  logic              skid_halt_q, skid_halt_d;
  logic              halted_q, halted_d;
  logic              in_ready_q, in_ready_d;
  logic              acc;
  logic              cons;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign out_halt  = head_halt_q;
  assign halted    = halted_q;
  assign acc       = in_valid && in_ready;
  assign cons      = out_valid && out_ready;

  generate
    if (SKID) begin : g_skid
      assign in_ready = in_ready_q;
    end else begin : g_single
      assign in_ready = (!out_valid || out_ready) && !halted_q;
    end
  endgenerate

  // Empty head slot always holds BUBBLE_VAL so out_data needs no mux.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    head_halt_d = head_halt_q;
    skid_d      = skid_q;
    skid_halt_d = skid_halt_q;
    halted_d    = halted_q || (cons && head_halt_q);
    if (flush) begin
      state_d     = EMPTY;
      head_d      = BUBBLE_VAL;
      head_halt_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d     = ONE;
            head_d      = in_data;
            head_halt_d = in_halt;
          end
        end
        ONE: begin
          unique case (1'b1)
            acc && cons: begin
              head_d      = in_data;
              head_halt_d = in_halt;
            end
            acc && !cons: begin
              state_d     = TWO;
              skid_d      = in_data;
              skid_halt_d = in_halt;
            end
            !acc && cons: begin
              state_d     = EMPTY;
              head_d      = BUBBLE_VAL;
              head_halt_d = 1'b0;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (cons) begin
            state_d     = ONE;
            head_d      = skid_q;
            head_halt_d = skid_halt_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO) && !halted_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      head_q      <= BUBBLE_VAL;
      head_halt_q <= 1'b0;
      skid_q      <= BUBBLE_VAL;
      skid_halt_q <= 1'b0;
      halted_q    <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      head_halt_q <= head_halt_d;
      skid_q      <= skid_d;
      skid_halt_q <= skid_halt_d;
      halted_q    <= halted_d;
      in_ready_q  <= in_ready_d;
    end
  end

  a_no_acc_in_two: assert property (
    @(posedge CLK) disable iff (!nRST) !(acc && state_q == TWO)
  );

`ifdef PIPE_STAGE_LATCH_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && out_valid && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
Parametrised, elastic inter-stage pipeline latch; the generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed bundle of DATA_W bits plus a halt flag.
- Replaces the single en/flush control with a valid/ready handshake, an optional skid entry, synchronous flush with bubble insertion, and a sticky halt.
- Sits between any two pipeline stages of the datapath.

Parameters:
DATA_W, 128, width of the packed stage bundle (instr, npc, rdat, control fields).
SKID, 1, 1 = two-entry skid buffer, in_ready fully registered; 0 = single entry, in_ready = !out_valid || out_ready (combinational).
BUBBLE_VAL, '0, DATA_W value driven on out_data when a slot is empty or flushed (NOP encoding).

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
in_valid  in  1  upstream presents a bundle.
in_ready  out  1  latch accepts the bundle this cycle.
in_data  in  DATA_W  upstream bundle.
in_halt  in  1  upstream bundle is the halt instruction.
out_valid  out  1  latch presents a bundle.
out_ready  in  1  downstream consumes the bundle this cycle.
out_data  out  DATA_W  head bundle, or BUBBLE_VAL when !out_valid.
out_halt  out  1  head bundle halt flag, 0 when !out_valid.
flush  in  1  squash all held bundles (branch/jump mispredict).
halted  out  1  sticky; a halt bundle has left the latch.

Behaviour:
- Accept = in_valid && in_ready. Consume = out_valid && out_ready. Bundles leave in strict arrival order.
- Reset (async, nRST=0): state EMPTY; out_valid=0, out_data=BUBBLE_VAL, out_halt=0, halted=0. in_ready=1 immediately after nRST deasserts. Reset mid-transfer discards all held bundles.
- SKID=1 state machine, states EMPTY, ONE (head only), TWO (head+skid):
  - EMPTY: accept -> ONE.
  - ONE: accept & !consume -> TWO (bundle into skid). Consume & !accept -> EMPTY. Accept & consume -> ONE (new head).
  - TWO: in_ready=0. Consume -> ONE (skid moves to head).
  - in_ready = (state != TWO) && !halted, registered.
- SKID=0: single register. Load on accept; clear to empty on consume without accept. in_ready = (!out_valid || out_ready) && !halted.
- Latency: a bundle accepted in cycle N is visible on out_* in cycle N+1.
- flush (synchronous):
  - Next state EMPTY; out_data=BUBBLE_VAL, out_halt=0 in cycle N+1.
  - A bundle accepted in the flush cycle is dropped. Flush beats accept and consume simultaneously; the consume in that cycle still counts downstream.
  - halted is unaffected by flush.
- Halt:
  - halted sets in the cycle after consume with out_halt=1.
  - Once set, in_ready=0 until reset. Bundles already held still drain.
- Holding: while out_valid && !out_ready, out_data and out_halt are stable.
- Wrap-around/overflow impossible by construction. Assertion: accept when state TWO is an error.

Optional Feature:
Macro PIPE_STAGE_LATCH_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[15:0], both reset to 0.
  - stall_cnt increments each cycle out_valid && !out_ready.
  - flush_cnt increments each cycle flush=1 while out_valid=1 or state!=EMPTY.
  - Both saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then stream: SKID=1, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 in cycles 1-3; in_ready stays 1.
- Backpressure: out_ready=0, push 0xA,0xB -> in_ready=0 after the 2nd accept; 0xC held upstream. out_ready=1 -> outputs 0xA,0xB,0xC in order, no loss or duplicate.
- Flush in TWO with in_valid=1 (0xD) -> next cycle out_valid=0, out_data=BUBBLE_VAL, 0xD dropped; flush_cnt=1 when STATS_EN.
- Halt: push 0x5 then 0x6 with in_halt=1, then 0x7 -> halted=1 one cycle after 0x6 consumed; in_ready=0; 0x7 never accepted. Flush leaves halted=1.
- SKID=0, out_ready toggling 1,0,1 with continuous in_valid -> in_ready equals !out_valid||out_ready each cycle; ordering preserved.
- Async reset asserted mid-cycle while in TWO -> outputs clear immediately without CLK; halted=0.
